// File: rtl/rx_temporal_cb_masked.sv
// RX temporal channel-bonding merger: per-lane FWFT skid FIFOs drained in strict
// round-robin over the enabled lanes, with mask-change realignment and a sticky skew monitor.
module rx_temporal_cb_masked #(
  parameter int unsigned DWIDTH     = 128,
  parameter int unsigned RATIO      = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SKEW_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RATIO-1:0]           lane_en,
  input  logic                       clr_err,
  input  logic [DWIDTH-1:0]          s_axis_tdata  [RATIO],
  input  logic [DWIDTH/8-1:0]        s_axis_tkeep  [RATIO],
  input  logic                       s_axis_tlast  [RATIO],
  input  logic                       s_axis_tvalid [RATIO],
  output logic                       s_axis_tready [RATIO],
  output logic [DWIDTH-1:0]          m_axis_tdata,
  output logic [DWIDTH/8-1:0]        m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(RATIO)-1:0]   cur_lane,
  output logic                       skew_err
);

  localparam int unsigned KW = DWIDTH / 8;
  localparam int unsigned EW = DWIDTH + KW + 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned LW = $clog2(RATIO);
  localparam int unsigned SW = $clog2(SKEW_LIMIT + 1);

  logic [EW-1:0]    mem_q    [RATIO][DEPTH];
  logic [AW-1:0]    wr_ptr_q [RATIO];
  logic [AW-1:0]    wr_ptr_d [RATIO];
  logic [AW-1:0]    rd_ptr_q [RATIO];
  logic [AW-1:0]    rd_ptr_d [RATIO];
  logic [CW-1:0]    cnt_q    [RATIO];
  logic [CW-1:0]    cnt_d    [RATIO];
  logic [RATIO-1:0] full;
  logic [RATIO-1:0] empty;
  logic [RATIO-1:0] push;
  logic [RATIO-1:0] pop_lane;

  logic [LW-1:0]    cur_lane_q, cur_lane_d;
  logic [RATIO-1:0] lane_en_q, lane_en_d;
  logic [SW-1:0]    skew_cnt_q, skew_cnt_d;
  logic             skew_err_q, skew_err_d;

  logic             realign;
  logic             pop;
  logic             stall;
  logic             others_full;
  logic [EW-1:0]    head;

  function automatic logic [LW-1:0] lowest_set(input logic [RATIO-1:0] m);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (!found && m[i]) begin
        lowest_set = LW'(i);
        found      = 1'b1;
      end
    end
  endfunction

  // Scan strictly after cur, wrapping; with a single enabled lane the scan lands back on cur.
  function automatic logic [LW-1:0] next_set(input logic [RATIO-1:0] m, input logic [LW-1:0] cur);
    logic        found;
    int unsigned idx;
    next_set = cur;
    found    = 1'b0;
    for (int unsigned k = 1; k <= RATIO; k++) begin
      idx = (32'(cur) + k) % RATIO;
      if (!found && m[idx]) begin
        next_set = LW'(idx);
        found    = 1'b1;
      end
    end
  endfunction

  always_comb begin
    realign     = (lane_en != lane_en_q);
    full        = '0;
    empty       = '0;
    push        = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      full[i]          = (cnt_q[i] == CW'(DEPTH));
      empty[i]         = (cnt_q[i] == '0);
      s_axis_tready[i] = lane_en[i] & ~full[i] & ~realign;
      push[i]          = s_axis_tvalid[i] & s_axis_tready[i];
    end

    head          = mem_q[cur_lane_q][rd_ptr_q[cur_lane_q]];
    m_axis_tvalid = lane_en[cur_lane_q] & ~empty[cur_lane_q] & ~realign;
    m_axis_tdata  = m_axis_tvalid ? head[EW-1 -: DWIDTH] : '0;
    m_axis_tkeep  = m_axis_tvalid ? head[KW:1]           : '0;
    m_axis_tlast  = m_axis_tvalid ? head[0]              : 1'b0;
    pop           = m_axis_tvalid & m_axis_tready;

    pop_lane = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      pop_lane[i] = pop & (cur_lane_q == LW'(i));
      if (realign || !lane_en[i]) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop_lane[i]);
        cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop_lane[i]);
      end
    end

    lane_en_d = lane_en;
    if (realign) begin
      cur_lane_d = lowest_set(lane_en);
    end else if (pop) begin
      cur_lane_d = next_set(lane_en, cur_lane_q);
    end else begin
      cur_lane_d = cur_lane_q;
    end

    others_full = 1'b0;
    for (int unsigned j = 0; j < RATIO; j++) begin
      if ((LW'(j) != cur_lane_q) && lane_en[j] && full[j]) others_full = 1'b1;
    end
    stall = empty[cur_lane_q] & others_full;

    if (realign || !stall) begin
      skew_cnt_d = '0;
    end else if (skew_cnt_q == SW'(SKEW_LIMIT)) begin
      skew_cnt_d = skew_cnt_q;
    end else begin
      skew_cnt_d = skew_cnt_q + 1'b1;
    end
    skew_err_d = (skew_cnt_d == SW'(SKEW_LIMIT)) | (skew_err_q & ~clr_err);

    cur_lane = cur_lane_q;
    skew_err = skew_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      cur_lane_q <= lowest_set(lane_en);
      lane_en_q  <= lane_en;
      skew_cnt_q <= '0;
      skew_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      cur_lane_q <= cur_lane_d;
      lane_en_q  <= lane_en_d;
      skew_cnt_q <= skew_cnt_d;
      skew_err_q <= skew_err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= {s_axis_tdata[i], s_axis_tkeep[i], s_axis_tlast[i]};
    end
  end

endmodule

// File: tb/tb_rx_temporal_cb_masked.sv
// Directed bench for rx_temporal_cb_masked with four 32-bit lanes; beat data carries its
// global sequence number, keep = ~data[3:0], last = data[0].
module tb_rx_temporal_cb_masked;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  lane_en = 4'hF;
  logic        clr_err = 1'b0;
  logic [31:0] s_tdata  [4];
  logic [3:0]  s_tkeep  [4];
  logic        s_tlast  [4];
  logic        s_tvalid [4];
  logic        s_tready [4];
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [1:0]  cur_lane;
  logic        skew_err;

  logic [31:0] lq [4][$];
  logic [31:0] obs_d [$];
  logic [3:0]  obs_k [$];
  logic        obs_l [$];
  logic [1:0]  obs_c [$];

  int checks = 0;
  int errors = 0;

  rx_temporal_cb_masked #(
    .DWIDTH(32),
    .RATIO(4),
    .DEPTH(4),
    .SKEW_LIMIT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lane_en(lane_en),
    .clr_err(clr_err),
    .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .cur_lane(cur_lane),
    .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  task automatic idle_lanes();
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i] = 1'b0;
      s_tdata[i]  = '0;
      s_tkeep[i]  = '0;
      s_tlast[i]  = 1'b0;
    end
  endtask

  // One clock: present queue heads, sample mid-cycle, retire accepted beats after the edge.
  task automatic tick();
    logic [31:0] d;
    bit          acc [4];
    for (int i = 0; i < 4; i++) begin
      if (lq[i].size() > 0) begin
        d           = lq[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = d;
        s_tkeep[i]  = ~d[3:0];
        s_tlast[i]  = d[0];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i]  = '0;
        s_tkeep[i]  = '0;
        s_tlast[i]  = 1'b0;
      end
    end
    #4;
    for (int i = 0; i < 4; i++) acc[i] = s_tvalid[i] && s_tready[i];
    if (m_tvalid && m_tready) begin
      obs_d.push_back(m_tdata);
      obs_k.push_back(m_tkeep);
      obs_l.push_back(m_tlast);
      obs_c.push_back(cur_lane);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) lq[i].delete(0);
  endtask

  task automatic do_reset(input logic [3:0] en);
    rst     = 1'b1;
    lane_en = en;
    clr_err = 1'b0;
    idle_lanes();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) lq[i].delete();
    obs_d.delete();
    obs_k.delete();
    obs_l.delete();
    obs_c.delete();
  endtask

  task automatic test_reset();
    do_reset(4'hF);
    #4;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", m_tvalid); end
    checks++; if (m_tdata !== 32'h0 || m_tkeep !== 4'h0 || m_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_outzero got %h/%h/%b want 0/0/0", m_tdata, m_tkeep, m_tlast);
    end
    checks++; if (cur_lane !== 2'd0) begin errors++; $display("FAIL reset_cur got %0d want 0", cur_lane); end
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL reset_skew got %0b want 0", skew_err); end
    @(posedge clk); #1;
    do_reset(4'b1100);
    checks++; if (cur_lane !== 2'd2) begin errors++; $display("FAIL reset_lowest got %0d want 2", cur_lane); end
  endtask

  task automatic test_no_lanes();
    do_reset(4'h0);
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i] = 1'b1;
      s_tdata[i]  = 32'h1;
    end
    #4;
    checks++; if (s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0 || s_tready[2] !== 1'b0 || s_tready[3] !== 1'b0) begin
      errors++; $display("FAIL none_tready got %b%b%b%b want 0000", s_tready[3], s_tready[2], s_tready[1], s_tready[0]);
    end
    checks++; if (cur_lane !== 2'd0) begin errors++; $display("FAIL none_cur got %0d want 0", cur_lane); end
    @(posedge clk); #5;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL none_tvalid got %0b want 0", m_tvalid); end
    @(posedge clk); #1;
    idle_lanes();
  endtask

  task automatic test_round_robin();
    do_reset(4'hF);
    m_tready = 1'b1;
    for (int k = 0; k < 12; k++) lq[k % 4].push_back(32'(k));
    for (int c = 0; c < 40 && obs_d.size() < 12; c++) tick();
    checks++; if (obs_d.size() != 12) begin errors++; $display("FAIL rr_count got %0d want 12", obs_d.size()); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (obs_d[k] !== 32'(k)) begin errors++; $display("FAIL rr_data[%0d] got %0d want %0d", k, obs_d[k], k); end
      checks++; if (obs_c[k] !== 2'(k % 4)) begin errors++; $display("FAIL rr_lane[%0d] got %0d want %0d", k, obs_c[k], k % 4); end
      checks++; if (obs_k[k] !== ~4'(k) || obs_l[k] !== 1'(k % 2)) begin
        errors++; $display("FAIL rr_keeplast[%0d] got %h/%b want %h/%b", k, obs_k[k], obs_l[k], ~4'(k), 1'(k % 2));
      end
    end
    #4;
    checks++; if (cur_lane !== 2'd0) begin errors++; $display("FAIL rr_wrap got %0d want 0", cur_lane); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rr_drained got %0b want 0", m_tvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_mask_1011();
    logic [1:0] exp_lane [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    do_reset(4'b1011);
    m_tready = 1'b1;
    checks++; if (cur_lane !== 2'd0) begin errors++; $display("FAIL m1011_cur got %0d want 0", cur_lane); end
    lq[0].push_back(32'd0); lq[0].push_back(32'd3);
    lq[1].push_back(32'd1); lq[1].push_back(32'd4);
    lq[3].push_back(32'd2); lq[3].push_back(32'd5);
    lq[2].push_back(32'd99);
    for (int c = 0; c < 30 && obs_d.size() < 6; c++) tick();
    checks++; if (obs_d.size() != 6) begin errors++; $display("FAIL m1011_count got %0d want 6", obs_d.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (obs_d[k] !== 32'(k) || obs_c[k] !== exp_lane[k]) begin
        errors++; $display("FAIL m1011_beat[%0d] got %0d@%0d want %0d@%0d", k, obs_d[k], obs_c[k], k, exp_lane[k]);
      end
    end
    checks++; if (lq[2].size() != 1) begin errors++; $display("FAIL m1011_lane2_taken got %0d left want 1", lq[2].size()); end
    #4;
    checks++; if (s_tready[2] !== 1'b0) begin errors++; $display("FAIL m1011_tready2 got %0b want 0", s_tready[2]); end
    checks++; if (cur_lane !== 2'd0) begin errors++; $display("FAIL m1011_wrap got %0d want 0", cur_lane); end
    @(posedge clk); #1;
    idle_lanes();
  endtask

  task automatic test_backpressure();
    int hold_bad = 0;
    do_reset(4'hF);
    m_tready = 1'b0;
    for (int k = 0; k < 16; k++) lq[k % 4].push_back(32'(k));
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c >= 1 && !(m_tvalid === 1'b1 && m_tdata === 32'd0 && m_tkeep === 4'hF && cur_lane === 2'd0)) hold_bad++;
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", hold_bad); end
    checks++; if (s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0 || s_tready[2] !== 1'b0 || s_tready[3] !== 1'b0) begin
      errors++; $display("FAIL bp_full got %b%b%b%b want 0000", s_tready[3], s_tready[2], s_tready[1], s_tready[0]);
    end
    checks++; if (lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size() != 0) begin
      errors++; $display("FAIL bp_accepted got %0d pending want 0", lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size());
    end
    m_tready = 1'b1;
    for (int c = 0; c < 40 && obs_d.size() < 16; c++) tick();
    tick();
    checks++; if (obs_d.size() != 16) begin errors++; $display("FAIL bp_count got %0d want 16", obs_d.size()); end
    for (int k = 0; k < 16; k++) begin
      checks++; if (obs_d[k] !== 32'(k)) begin errors++; $display("FAIL bp_data[%0d] got %0d want %0d", k, obs_d[k], k); end
    end
  endtask

  task automatic test_realign();
    logic [1:0] exp_lane [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset(4'hF);
    m_tready = 1'b1;
    for (int k = 0; k < 8; k++) lq[k % 4].push_back(32'(k));
    for (int c = 0; c < 3; c++) tick();
    checks++; if (obs_d.size() != 2 || obs_d[0] !== 32'd0 || obs_d[1] !== 32'd1) begin
      errors++; $display("FAIL ra_pre got %0d beats want 2 (0,1)", obs_d.size());
    end
    lane_en = 4'h7;
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i] = 1'b1;
      s_tdata[i]  = 32'hEE;
    end
    #4;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ra_tvalid got %0b want 0", m_tvalid); end
    checks++; if (s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0 || s_tready[2] !== 1'b0 || s_tready[3] !== 1'b0) begin
      errors++; $display("FAIL ra_tready got %b%b%b%b want 0000", s_tready[3], s_tready[2], s_tready[1], s_tready[0]);
    end
    @(posedge clk); #1;
    idle_lanes();
    #4;
    checks++; if (m_tvalid !== 1'b0 || cur_lane !== 2'd0) begin
      errors++; $display("FAIL ra_after got tvalid=%0b cur=%0d want 0/0", m_tvalid, cur_lane);
    end
    checks++; if (s_tready[0] !== 1'b1 || s_tready[1] !== 1'b1 || s_tready[2] !== 1'b1 || s_tready[3] !== 1'b0) begin
      errors++; $display("FAIL ra_empty got %b%b%b%b want 0111", s_tready[3], s_tready[2], s_tready[1], s_tready[0]);
    end
    @(posedge clk); #1;
    obs_d.delete(); obs_c.delete(); obs_k.delete(); obs_l.delete();
    for (int k = 0; k < 6; k++) lq[k % 3].push_back(32'(100 + k));
    for (int c = 0; c < 30 && obs_d.size() < 6; c++) tick();
    checks++; if (obs_d.size() != 6) begin errors++; $display("FAIL ra_count got %0d want 6", obs_d.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (obs_d[k] !== 32'(100 + k) || obs_c[k] !== exp_lane[k]) begin
        errors++; $display("FAIL ra_beat[%0d] got %0d@%0d want %0d@%0d", k, obs_d[k], obs_c[k], 100 + k, exp_lane[k]);
      end
    end
  endtask

  task automatic test_skew();
    do_reset(4'hF);
    m_tready = 1'b1;
    for (int k = 1; k < 16; k++) if (k % 4 != 0) lq[k % 4].push_back(32'(k));
    for (int c = 0; c < 19; c++) tick();
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL skew_early got %0b want 0", skew_err); end
    tick();
    checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL skew_set got %0b want 1", skew_err); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL skew_setwins got %0b want 1", skew_err); end
    m_tready = 1'b0;
    lq[0].push_back(32'd50);
    tick();
    tick();
    checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL skew_sticky got %0b want 1", skew_err); end
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd50) begin
      errors++; $display("FAIL skew_head got %0b/%0d want 1/50", m_tvalid, m_tdata);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL skew_clr got %0b want 0", skew_err); end
  endtask

  task automatic test_reset_midburst();
    do_reset(4'hF);
    m_tready = 1'b0;
    for (int k = 1; k < 16; k++) if (k % 4 != 0) lq[k % 4].push_back(32'(k));
    for (int c = 0; c < 21; c++) tick();
    lq[0].push_back(32'd60);
    tick();
    checks++; if (skew_err !== 1'b1 || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL rmb_pre got skew=%0b tvalid=%0b want 1/1", skew_err, m_tvalid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (m_tvalid !== 1'b0 || m_tdata !== 32'd0) begin
      errors++; $display("FAIL rmb_out got %0b/%0d want 0/0", m_tvalid, m_tdata);
    end
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL rmb_skew got %0b want 0", skew_err); end
    checks++; if (s_tready[0] !== 1'b1 || s_tready[1] !== 1'b1 || s_tready[2] !== 1'b1 || s_tready[3] !== 1'b1) begin
      errors++; $display("FAIL rmb_empty got %b%b%b%b want 1111", s_tready[3], s_tready[2], s_tready[1], s_tready[0]);
    end
    m_tready = 1'b1;
    tick();
    checks++; if (m_tvalid !== 1'b0 || obs_d.size() != 0) begin
      errors++; $display("FAIL rmb_flushed got tvalid=%0b beats=%0d want 0/0", m_tvalid, obs_d.size());
    end
  endtask

  initial begin
    idle_lanes();
    test_reset();
    test_no_lanes();
    test_round_robin();
    test_mask_1011();
    test_backpressure();
    test_realign();
    test_skew();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
